hilo_md_unit: RTL and testbench
===============================

Name: hilo_md_unit

Overview:
- Owns the architectural HI/LO register pair and performs MULT/MULTU (single-cycle) and DIV/DIVU (iterative, 32 cycles).
- Sits beside the EX-stage ALU and closes the HILO loop. It receives the ALU's 64-bit MTHI/MTLO write data, and its `hilo` output feeds the ALU's hilo input for MFHI/MFLO.
- Drives a stall to the pipeline control while a division is in progress.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hilo_we  in  1  MTHI/MTLO write strobe from EX
- hilo_wdata  in  64  ALU aluout_64, laid out as {HI,LO}
- md_start  in  1  multiply/divide instruction present in EX
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  rs operand (dividend / multiplicand)
- src_b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  exception flush; cancels any in-flight operation
- hilo  out  64  current {HI,LO}, registered
- stall  out  1  pipeline stall request
- md_done  out  1  one-cycle pulse when a division result is written

Behaviour:
- Reset (sync, priority over everything):
  - hilo=0, state=IDLE, md_done=0, iteration counter=0.
  - stall is forced to 0 while rst=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - flush=1: md_start and hilo_we are ignored; remain IDLE.
  - md_start with MULT/MULTU: hilo <= signed/unsigned 64-bit product at the next edge. No stall.
  - md_start with DIV/DIVU and src_b!=0:
    - Latch operand magnitudes, sign flags and the unsigned flag.
    - stall=1 combinationally in this cycle.
    - Next state RUN, counter=0.
  - md_start with DIV/DIVU and src_b==0:
    - Next state DONE, no stall.
    - hilo <= {src_a, all-ones} at the edge; no sign fixup.
  - md_start has priority over hilo_we in the same cycle.
  - Otherwise, if hilo_we: hilo <= hilo_wdata at the next edge.
- RUN:
  - One restoring radix-2 iteration per cycle: shift remainder, conditionally subtract the divisor, shift in a quotient bit.
  - stall=1 throughout. md_start and hilo_we are ignored.
  - On the edge completing iteration WIDTH-1 (the 32nd RUN cycle), apply the sign fixup and write hilo <= {remainder, quotient}. Next state DONE.
  - flush=1 in RUN: return to IDLE at the edge, hilo unchanged, no md_done.
- Signed division:
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- DONE:
  - md_done=1 and stall=0.
  - hilo already holds the result and is visible to MFHI/MFLO forwarding.
  - md_start is ignored, because the same DIV instruction is still in EX this cycle.
  - hilo_we is honoured unless flush=1.
  - Unconditional transition to IDLE.
- Timing: total stall for a non-zero divide is 1 + WIDTH = 33 cycles (start cycle plus RUN). The result is observable in the DONE cycle.
- stall = (state==RUN) | (state==IDLE & md_start & md_op[1] & src_b!=0 & ~flush & ~rst).
- md_done is registered: high only in the DONE cycle.

Decomposition:
- Shared header: md_op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encodings, and WIDTH default.
- Sub-module div_iter: unsigned iterative core with load/step inputs and quotient/remainder outputs.
- Sign handling, the multiplier and the FSM stay in hilo_md_unit.

Test Plan:
- hilo_we=1, hilo_wdata=0x00000005_00000000 -> next cycle hilo=0x00000005_00000000; stall never high.
- MULT src_a=0xFFFFFFFD, src_b=7 -> next cycle hilo=0xFFFFFFFF_FFFFFFEB. MULTU with the same operands -> 0x00000006_FFFFFFEB. stall=0.
- DIVU 100/7 -> stall high 33 consecutive cycles, then DONE cycle with hilo={0x2,0xE}, md_done=1 for exactly 1 cycle. md_start held high through DONE does not restart the divide.
- Signed DIV cases:
  - DIV -7/2 -> hilo={0xFFFFFFFF,0xFFFFFFFD}.
  - DIV 0x80000000/0xFFFFFFFF -> hilo={0,0x80000000}.
- flush asserted in the 10th RUN cycle:
  - hilo keeps its prior value; stall low next cycle; no md_done.
  - A following MTLO write succeeds.
- DIVU 0x1234/0 -> no stall, DONE next cycle with hilo={0x00001234,0xFFFFFFFF}. rst asserted mid-RUN -> hilo=0, state IDLE, stall=0 next cycle.

Source files
------------

// File: rtl/hilo_md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_unit_pkg
// Brief    : Shared md_op codes, FSM encodings and default width for the HI/LO unit.
// Revision : 1.0
// ============================================================================
package hilo_md_unit_pkg;

    localparam int c_WIDTH = 32;

    localparam logic [1:0] c_MD_MULT  = 2'b00;
    localparam logic [1:0] c_MD_MULTU = 2'b01;
    localparam logic [1:0] c_MD_DIV   = 2'b10;
    localparam logic [1:0] c_MD_DIVU  = 2'b11;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hilo_md_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_unit_div_iter
// Brief    : Unsigned restoring radix-2 divider core, one quotient bit per step.
// Revision : 1.0
// ============================================================================
module hilo_md_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next,
    output logic [WIDTH-1:0] remainder_next
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // The dividend shifts out of r_quo's top as quotient bits shift in below.
    assign w_trial        = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};
    assign w_fits         = ~w_trial[WIDTH];
    assign remainder_next = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign quotient_next  = {r_quo[WIDTH-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dsr <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dsr <= divisor;
        end else if (step) begin
            r_rem <= remainder_next;
            r_quo <= quotient_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_unit
// Brief    : HI/LO register pair with single-cycle multiply and iterative divide.
// Revision : 1.0
// ============================================================================
module hilo_md_unit
    import hilo_md_unit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hilo_we,
    input  logic [2*WIDTH-1:0] hilo_wdata,
    input  logic               md_start,
    input  logic [1:0]         md_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    output logic [2*WIDTH-1:0] hilo,
    output logic               stall,
    output logic               md_done
);

    localparam int                c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_hilo;
    logic               r_done;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_is_div;
    logic               w_mul_signed;
    logic               w_div_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_nonzero;
    logic               w_div_start;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_div     = (md_op == c_MD_DIV) | (md_op == c_MD_DIVU);
    assign w_mul_signed = (md_op == c_MD_MULT);
    assign w_div_signed = (md_op == c_MD_DIV);

    assign w_a_neg     = w_div_signed & src_a[WIDTH-1];
    assign w_b_neg     = w_div_signed & src_b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -src_a : src_a;
    assign w_b_mag     = w_b_neg ? -src_b : src_b;
    assign w_b_nonzero = |src_b;

    assign w_div_start = (r_state == c_S_IDLE) & md_start & w_is_div & w_b_nonzero & ~flush;
    assign stall       = ~rst & ((r_state == c_S_RUN) | w_div_start);

    // Operands extended to full product width so the low 2*WIDTH bits are exact.
    assign w_prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign w_prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    assign w_quo_fix = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem_fix = r_neg_r ? -w_rem_next : w_rem_next;

    hilo_md_unit_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk            (clk),
        .rst            (rst),
        .load           (w_div_start),
        .step           (r_state == c_S_RUN),
        .dividend       (w_a_mag),
        .divisor        (w_b_mag),
        .quotient_next  (w_quo_next),
        .remainder_next (w_rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_hilo  <= '0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            unique case (r_state)
                c_S_IDLE: begin
                    r_done <= 1'b0;
                    if (!flush) begin
                        if (md_start) begin
                            if (!w_is_div) begin
                                r_hilo <= w_mul_signed ? w_prod_s : w_prod_u;
                            end else if (w_b_nonzero) begin
                                r_state <= c_S_RUN;
                                r_cnt   <= '0;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                            end else begin
                                r_hilo  <= {src_a, {WIDTH{1'b1}}};
                                r_state <= c_S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (hilo_we) begin
                            r_hilo <= hilo_wdata;
                        end
                    end
                end
                c_S_RUN: begin
                    if (flush) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_hilo  <= {w_rem_fix, w_quo_fix};
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_S_DONE: begin
                    // The divide instruction is still in EX, so md_start is not a new request.
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                    if (hilo_we && !flush) begin
                        r_hilo <= hilo_wdata;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign hilo    = r_hilo;
    assign md_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_md_unit
// Brief    : Directed self-checking bench for hilo_md_unit.
// Revision : 1.0
// ============================================================================
module tb_hilo_md_unit;

    logic        clk;
    logic        rst;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [63:0] hilo;
    logic        stall;
    logic        md_done;

    int checks = 0;
    int errors = 0;

    hilo_md_unit #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .md_start   (md_start),
        .md_op      (md_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hilo       (hilo),
        .stall      (stall),
        .md_done    (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a non-zero divide, count stall cycles, then check the DONE cycle.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_hilo);
        int n;
        md_start = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'd33);
        check({tag, "_hilo"}, hilo, exp_hilo);
        check({tag, "_done"}, {63'd0, md_done}, 64'd1);
        // md_start stays high through DONE and must not restart the divide.
        tick();
        md_start = 1'b0;
        #1;
        check({tag, "_no_restart_stall"}, {63'd0, stall}, 64'd0);
        check({tag, "_done_pulse"}, {63'd0, md_done}, 64'd0);
        check({tag, "_hilo_hold"}, hilo, exp_hilo);
    endtask

    initial begin
        logic [63:0] prior;

        rst        = 1'b1;
        hilo_we    = 1'b0;
        hilo_wdata = '0;
        md_start   = 1'b0;
        md_op      = 2'b00;
        src_a      = '0;
        src_b      = '0;
        flush      = 1'b0;
        tick();
        tick();
        check("reset_stall_in_rst", {63'd0, stall}, 64'd0);
        rst = 1'b0;
        #1;
        check("reset_hilo", hilo, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_done", {63'd0, md_done}, 64'd0);

        // MTHI-style write
        hilo_we    = 1'b1;
        hilo_wdata = 64'h00000005_00000000;
        #1;
        check("mthi_stall", {63'd0, stall}, 64'd0);
        tick();
        hilo_we = 1'b0;
        check("mthi_hilo", hilo, 64'h00000005_00000000);

        // MULT / MULTU
        md_start = 1'b1;
        md_op    = 2'b00;
        src_a    = 32'hFFFFFFFD;
        src_b    = 32'd7;
        #1;
        check("mult_stall", {63'd0, stall}, 64'd0);
        tick();
        check("mult_hilo", hilo, 64'hFFFFFFFF_FFFFFFEB);
        md_op = 2'b01;
        #1;
        check("multu_stall", {63'd0, stall}, 64'd0);
        tick();
        check("multu_hilo", hilo, 64'h00000006_FFFFFFEB);
        md_start = 1'b0;

        // Divides
        run_div("divu_100_7", 2'b11, 32'd100, 32'd7, {32'h2, 32'hE});
        run_div("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("div_wrap", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});

        // Flush during the 10th RUN cycle
        prior    = hilo;
        md_start = 1'b1;
        md_op    = 2'b11;
        src_a    = 32'd100;
        src_b    = 32'd7;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        check("flush_run_stall", {63'd0, stall}, 64'd1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_stall_after", {63'd0, stall}, 64'd0);
        check("flush_hilo_kept", hilo, prior);
        check("flush_no_done", {63'd0, md_done}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("flush_no_done_late", {63'd0, md_done}, 64'd0);
        end
        hilo_we    = 1'b1;
        hilo_wdata = {prior[63:32], 32'h0000ABCD};
        tick();
        hilo_we = 1'b0;
        check("mtlo_after_flush", hilo, {prior[63:32], 32'h0000ABCD});

        // Divide by zero
        md_start = 1'b1;
        md_op    = 2'b11;
        src_a    = 32'h00001234;
        src_b    = 32'd0;
        #1;
        check("div0_stall", {63'd0, stall}, 64'd0);
        tick();
        check("div0_hilo", hilo, {32'h00001234, 32'hFFFFFFFF});
        check("div0_done", {63'd0, md_done}, 64'd1);
        check("div0_done_stall", {63'd0, stall}, 64'd0);
        md_start = 1'b0;
        tick();
        check("div0_done_pulse", {63'd0, md_done}, 64'd0);

        // Reset in the middle of a divide
        md_start = 1'b1;
        md_op    = 2'b11;
        src_a    = 32'd100;
        src_b    = 32'd7;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_stall_forced", {63'd0, stall}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_hilo", hilo, 64'd0);
        check("rst_mid_stall", {63'd0, stall}, 64'd0);
        check("rst_mid_done", {63'd0, md_done}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("rst_mid_no_done", {63'd0, md_done}, 64'd0);
        end

        // Unit must be back in IDLE and accept a new multiply
        md_start = 1'b1;
        md_op    = 2'b00;
        src_a    = 32'd3;
        src_b    = 32'hFFFFFFFC;
        tick();
        md_start = 1'b0;
        check("post_rst_mult", hilo, 64'hFFFFFFFF_FFFFFFF4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
